// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmitter: FSM state encodings and status bit positions.
// Defining UART_TX_PARITY_EN adds the PARITY state and widens the state register to 3 bits.
package uart_tx_pkg;

  localparam int unsigned UART_STA_BUSY = 0;
  localparam int unsigned UART_STA_DONE = 1;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    UART_TX_IDLE   = 3'd0,
    UART_TX_START  = 3'd1,
    UART_TX_DATA   = 3'd2,
    UART_TX_STOP   = 3'd3,
    UART_TX_PARITY = 3'd4
  } uart_tx_state_e;
`else
  typedef enum logic [1:0] {
    UART_TX_IDLE  = 2'd0,
    UART_TX_START = 2'd1,
    UART_TX_DATA  = 2'd2,
    UART_TX_STOP  = 2'd3
  } uart_tx_state_e;
`endif

endpackage

// File: rtl/uart_tx_if.sv
// Memory-controller side of the UART0 transmitter: send strobe, character, serial line, status.
interface uart_tx_if;
  logic       send_i_w;
  logic [7:0] schar_i_w;
  logic       tx_o_r;
  logic [1:0] sta_o_r;

  modport master (output send_i_w, schar_i_w, input  tx_o_r, sta_o_r);
  modport slave  (input  send_i_w, schar_i_w, output tx_o_r, sta_o_r);
endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and pulses tick_o on the last count.
// Synchronous active-low reset; clear_i restarts the period from zero.
module uart_baud_gen #(
  parameter int unsigned CLKS_PER_BIT = 234,
  parameter int unsigned CNT_W        = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  output logic tick_o
);

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    tick_o = (cnt_q == LastCnt);
    cnt_d  = cnt_q + CNT_W'(1);
    if (clear_i || tick_o) cnt_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 serial transmitter for the UART0 window; a 0->1 on send starts a frame when idle.
// Defining UART_TX_PARITY_EN inserts an even-parity bit between the data bits and the stop bit.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 234,
  parameter int unsigned CNT_W        = 16
) (
  input logic      clk_i_w,
  input logic      rst_i_w,
  uart_tx_if.slave bus
);

  uart_tx_state_e state_q, state_d;
  logic [2:0]     bit_idx_q, bit_idx_d;
  logic [7:0]     shift_q, shift_d;
  logic           send_q, send_d;
  logic           tx_q, tx_d;
  logic [1:0]     sta_q, sta_d;
  logic           rise, clear, tick;
`ifdef UART_TX_PARITY_EN
  logic           par_q, par_d;
`endif

  uart_baud_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .CNT_W        (CNT_W)
  ) u_baud (
    .clk_i   (clk_i_w),
    .rst_ni  (rst_i_w),
    .clear_i (clear),
    .tick_o  (tick)
  );

  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    sta_d     = sta_q;
    send_d    = bus.send_i_w;
    clear     = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d     = par_q;
`endif
    rise      = bus.send_i_w & ~send_q;

    unique case (state_q)
      UART_TX_IDLE: begin
        if (rise) begin
          shift_d              = bus.schar_i_w;
          state_d              = UART_TX_START;
          clear                = 1'b1;
          sta_d[UART_STA_BUSY] = 1'b1;
          sta_d[UART_STA_DONE] = 1'b0;
`ifdef UART_TX_PARITY_EN
          par_d                = ^bus.schar_i_w;
`endif
        end
      end
      UART_TX_START: begin
        if (tick) begin
          state_d   = UART_TX_DATA;
          bit_idx_d = 3'd0;
        end
      end
      UART_TX_DATA: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = UART_TX_PARITY;
`else
            state_d = UART_TX_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      UART_TX_PARITY: begin
        if (tick) state_d = UART_TX_STOP;
      end
`endif
      UART_TX_STOP: begin
        if (tick) begin
          state_d              = UART_TX_IDLE;
          sta_d[UART_STA_BUSY] = 1'b0;
          sta_d[UART_STA_DONE] = 1'b1;
        end
      end
      default: state_d = UART_TX_IDLE;
    endcase

    // Line is registered, so it is decoded from the state being entered.
    case (state_d)
      UART_TX_START:  tx_d = 1'b0;
      UART_TX_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      UART_TX_PARITY: tx_d = par_q;
`endif
      default:        tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i_w) begin
    if (!rst_i_w) begin
      state_q   <= UART_TX_IDLE;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'd0;
      send_q    <= 1'b0;
      tx_q      <= 1'b1;
      sta_q     <= 2'b00;
`ifdef UART_TX_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      send_q    <= send_d;
      tx_q      <= tx_d;
      sta_q     <= sta_d;
`ifdef UART_TX_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

  assign bus.tx_o_r  = tx_q;
  assign bus.sta_o_r = sta_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: a waveform-level reference model queues the expected line and
// status per cycle; a monitor on the falling edge pops and compares against the DUT.
module tb_uart_tx;

  localparam int unsigned Cpb = 4;
`ifdef UART_TX_PARITY_EN
  localparam bit HasParity = 1'b1;
`else
  localparam bit HasParity = 1'b0;
`endif

  typedef struct packed {
    logic       tx;
    logic [1:0] sta;
  } exp_t;

  logic clk;
  logic rst;
  uart_tx_if bus ();

  uart_tx #(
    .CLKS_PER_BIT (Cpb),
    .CNT_W        (3)
  ) dut (
    .clk_i_w (clk),
    .rst_i_w (rst),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // Reference model: a frame is just a list of line levels, one per remaining clock.
  initial begin : model
    logic wave_q[$];
    logic m_done;
    logic m_prev;
    exp_t e;
    logic [7:0] b;
    logic bits[$];
    m_done = 1'b0;
    m_prev = 1'b0;
    forever begin
      @(posedge clk);
      if (!rst) begin
        wave_q.delete();
        m_done = 1'b0;
        m_prev = 1'b0;
      end else begin
        if (wave_q.size() != 0) begin
          void'(wave_q.pop_front());
          if (wave_q.size() == 0) m_done = 1'b1;
        end else if (bus.send_i_w && !m_prev) begin
          b = bus.schar_i_w;
          bits.delete();
          bits.push_back(1'b0);
          for (int i = 0; i < 8; i++) bits.push_back(b[i]);
          if (HasParity) bits.push_back(^b);
          bits.push_back(1'b1);
          foreach (bits[k]) for (int j = 0; j < int'(Cpb); j++) wave_q.push_back(bits[k]);
          m_done = 1'b0;
        end
        m_prev = bus.send_i_w;
      end
      e.tx  = (wave_q.size() != 0) ? wave_q[0] : 1'b1;
      e.sta = (wave_q.size() != 0) ? 2'b01 : {m_done, 1'b0};
      exp_q.push_back(e);
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        if (bus.tx_o_r !== e.tx) begin
          errors++;
          $display("FAIL tx cycle %0d: got %b expected %b", cyc, bus.tx_o_r, e.tx);
        end
        checks++;
        if (bus.sta_o_r !== e.sta) begin
          errors++;
          $display("FAIL sta cycle %0d: got %b expected %b", cyc, bus.sta_o_r, e.sta);
        end
      end
    end
  end

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] c, input int unsigned hold);
    bus.schar_i_w = c;
    bus.send_i_w  = 1'b1;
    tick(hold);
    bus.send_i_w  = 1'b0;
    tick(2);
  endtask

  initial begin : stim
    rst           = 1'b0;
    bus.send_i_w  = 1'b0;
    bus.schar_i_w = 8'h00;
    tick(3);
    rst = 1'b1;
    tick(20);

    send_byte(8'h55, 50);

    // Byte change and second rise mid-frame are both ignored.
    bus.schar_i_w = 8'hA3;
    bus.send_i_w  = 1'b1;
    tick(10);
    bus.schar_i_w = 8'hFF;
    bus.send_i_w  = 1'b0;
    tick(2);
    bus.send_i_w  = 1'b1;
    tick(40);
    bus.send_i_w  = 1'b0;
    tick(5);

    // Reset partway through a frame, then a clean frame.
    bus.schar_i_w = 8'h00;
    bus.send_i_w  = 1'b1;
    tick(17);
    rst = 1'b0;
    tick(1);
    rst = 1'b1;
    bus.send_i_w = 1'b0;
    tick(3);
    send_byte(8'h41, 45);

    // Done is sticky across send falling; a new rise clears it.
    bus.send_i_w = 1'b1;
    tick(5);
    bus.send_i_w = 1'b0;
    tick(5);
    send_byte(8'h0D, 50);

    send_byte(8'h07, 50);
    send_byte(8'h03, 50);

    // Rise landing right as a frame ends is ignored.
    bus.schar_i_w = 8'h5A;
    bus.send_i_w  = 1'b1;
    tick(1);
    bus.send_i_w  = 1'b0;
    tick(HasParity ? 11 * Cpb - 2 : 10 * Cpb - 2);
    bus.send_i_w  = 1'b1;
    tick(1);
    bus.send_i_w  = 1'b0;
    tick(50);

    for (int i = 0; i < 40; i++) begin
      bus.schar_i_w = 8'($urandom);
      bus.send_i_w  = ~bus.send_i_w;
      if ($urandom_range(0, 15) == 0) begin
        rst = 1'b0;
        tick(1);
        rst = 1'b1;
      end
      tick($urandom_range(1, 50));
    end
    bus.send_i_w = 1'b0;
    tick(60);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
